pipelined_ling_addsub: RTL and testbench

PIPELINED_LING_ADDSUB -- requirements
Module: pipelined_ling_addsub

---
 rtl/pipelined_ling_addsub.sv | 135 +++++++++++++
 tb/tb_pipelined_ling_addsub.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ling_addsub.sv
`default_nettype none
// pipelined_ling_addsub: two-stage add/sub using Ling pseudo-carries in 4-bit sub-blocks,
// 8-bit group generate/propagate and lookahead across groups. Rev 1.0
module pipelined_ling_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG = WIDTH / 8;

  // Carries into bits 0..3 of a sub-block; h(i+1) = g(i) | t(i-1)&h(i), c(i) = t(i-1)&h(i)
  function automatic logic [3:0] ling_carries(input logic [2:0] g, input logic [2:0] t,
                                              input logic cb);
    logic h1, h2, h3;
    h1 = g[0] | cb;
    h2 = g[1] | g[0] | (t[0] & cb);
    h3 = g[2] | g[1] | (t[1] & g[0]) | (t[1] & t[0] & cb);
    return {t[2] & h3, t[1] & h2, t[0] & h1, cb};
  endfunction

  function automatic logic ling_cout(input logic [3:0] g, input logic [3:0] t, input logic cb);
    logic h4;
    h4 = g[3] | g[2] | (t[2] & g[1]) | (t[2] & t[1] & g[0]) | (t[2] & t[1] & t[0] & cb);
    return t[3] & h4;
  endfunction

  logic             s1_valid, s1_sub, s1_cin, s1_chain;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [NG-1:0]    s1_gg, s1_gp;
  logic             carry_reg;

  logic             s1_adv, accept;
  logic [WIDTH-1:0] b_eff, p1, p2, cbit, sum_c;
  logic [NG-1:0]    gg_c, gp_c;
  logic [NG:0]      eg, grp_c;
  logic             cin_eff, cout_c, ovf_c, c_acc, term, c_mid;

  assign s1_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s1_adv;
  assign accept   = in_valid & in_ready;
  assign b_eff    = sub ? ~b : b;
  assign p1       = a ^ b_eff;

  always_comb begin
    gg_c = '0;
    gp_c = '0;
    for (int k = 0; k < NG; k++) begin
      gp_c[k] = &p1[8*k +: 8];
      gg_c[k] = ling_cout(a[8*k+4 +: 4] & b_eff[8*k+4 +: 4], a[8*k+4 +: 4] | b_eff[8*k+4 +: 4], 1'b0)
              | (&p1[8*k+4 +: 4]
                 & ling_cout(a[8*k +: 4] & b_eff[8*k +: 4], a[8*k +: 4] | b_eff[8*k +: 4], 1'b0));
    end
  end

  assign cin_eff = s1_chain ? carry_reg : (s1_sub | s1_cin);
  assign eg      = {s1_gg, cin_eff};
  assign p2      = s1_a ^ s1_b;

  // Group carry k is the OR over every earlier generate gated by all propagates in between.
  always_comb begin
    grp_c = '0;
    cbit  = '0;
    c_acc = 1'b0;
    term  = 1'b0;
    c_mid = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      c_acc = 1'b0;
      for (int j = 0; j <= k; j++) begin
        term = eg[j];
        for (int m = j + 1; m <= k; m++) term = term & s1_gp[m-1];
        c_acc = c_acc | term;
      end
      grp_c[k] = c_acc;
    end
    for (int k = 0; k < NG; k++) begin
      c_mid = ling_cout(s1_a[8*k +: 4] & s1_b[8*k +: 4], s1_a[8*k +: 4] | s1_b[8*k +: 4], grp_c[k]);
      cbit[8*k +: 4]   = ling_carries(s1_a[8*k +: 3] & s1_b[8*k +: 3],
                                      s1_a[8*k +: 3] | s1_b[8*k +: 3], grp_c[k]);
      cbit[8*k+4 +: 4] = ling_carries(s1_a[8*k+4 +: 3] & s1_b[8*k+4 +: 3],
                                      s1_a[8*k+4 +: 3] | s1_b[8*k+4 +: 3], c_mid);
    end
  end

  assign sum_c  = p2 ^ cbit;
  assign cout_c = grp_c[NG];
  assign ovf_c  = cbit[WIDTH-1] ^ cout_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      carry_reg <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          sum       <= sum_c;
          cout      <= cout_c;
          ovf       <= ovf_c;
          carry_reg <= cout_c;
        end
      end
      if (in_ready) s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a     <= a;
      s1_b     <= b_eff;
      s1_sub   <= sub;
      s1_cin   <= cin;
      s1_chain <= chain;
      s1_gg    <= gg_c;
      s1_gp    <= gp_c;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pipelined_ling_addsub.sv
`default_nettype none
// tb_pipelined_ling_addsub: table vectors, backpressure and reset sequences,
// multi-width random regression against an arithmetic reference model.
module tb_pipelined_ling_addsub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          n_vec = 0;
  int          n_err = 0;
  logic        rand_go = 1'b0;
  int          rand_done = 0;

  logic        in_valid, in_ready, cin, sub, chain, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  pipelined_ling_addsub #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .chain(chain),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        chain;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl[12];

  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic vcin, input logic vsub, input logic vchain, input logic vvalid);
    a = va; b = vb; cin = vcin; sub = vsub; chain = vchain; in_valid = vvalid;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    drive(v.a, v.b, v.cin, v.sub, v.chain, 1'b1);
    #1;
    check($sformatf("in_ready[%0d]", idx), in_ready, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check($sformatf("latency[%0d]", idx), lat, 2);
    check($sformatf("sum[%0d]", idx), sum, v.sum);
    check($sformatf("cout[%0d]", idx), cout, v.cout);
    check($sformatf("ovf[%0d]", idx), ovf, v.ovf);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[2]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[3]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[4]  = '{32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h00000002, 1'b0, 1'b0};
    tbl[5]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[6]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0};
    tbl[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[8]  = '{32'h00000003, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
    tbl[9]  = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b0, 32'hACF13569, 1'b0, 1'b0};
    tbl[10] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 1'b1, 32'h0000000A, 1'b0, 1'b0};
    tbl[11] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset ovf", ovf, 0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    // three back-to-back beats against a stalled consumer
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 check("bp accept0", in_ready, 1);
    @(negedge clk);
    drive(32'd10, 32'd20, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 check("bp accept1", in_ready, 1);
    @(negedge clk);
    drive(32'd100, 32'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    check("bp stall in_ready", in_ready, 0);
    check("bp out_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("bp hold sum", sum, 32'd3);
      check("bp hold in_ready", in_ready, 0);
      check("bp hold out_valid", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("bp release in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp beat1 valid", out_valid, 1);
    check("bp beat1 sum", sum, 32'h1E);
    @(negedge clk);
    #1;
    check("bp beat2 valid", out_valid, 1);
    check("bp beat2 sum", sum, 32'h63);
    check("bp beat2 cout", cout, 1);
    @(negedge clk);
    #1 check("bp drained", out_valid, 0);

    // reset with both stages full, carry_reg set
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("rst pre out_valid", out_valid, 1);
    check("rst pre cout", cout, 1);
    check("rst pre in_ready", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst sum", sum, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("rst no stale output", out_valid, 0);
    end
    v = '{32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0};
    run_vec(v, 100);

    rand_go = 1'b1;
    for (int t = 0; t < 4000 && rand_done < 4; t++) @(posedge clk);
    check("rand completion", rand_done, 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rand
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 32 : (gi == 2) ? 72 : 128;
    logic         r_iv, r_ir, r_cin, r_sub, r_chain, r_ov, r_or, r_cout, r_ovf;
    logic [W-1:0] r_a, r_b, r_sum;
    logic [W+1:0] q[$];

    pipelined_ling_addsub #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(r_iv), .in_ready(r_ir),
      .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub), .chain(r_chain),
      .out_valid(r_ov), .out_ready(r_or), .sum(r_sum), .cout(r_cout), .ovf(r_ovf)
    );

    initial begin
      logic         mc, ce, o;
      logic [127:0] ra, rb;
      logic [W-1:0] be;
      logic [W:0]   full;
      logic [W+1:0] e;
      r_iv = 1'b0; r_or = 1'b1; r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0; r_chain = 1'b0;
      mc = 1'b0;
      wait (rand_go);
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        if (cyc < 2900) begin
          ra = {$urandom(), $urandom(), $urandom(), $urandom()};
          rb = {$urandom(), $urandom(), $urandom(), $urandom()};
          case ($urandom_range(0, 7))
            0: ra = '1;
            1: rb = '1;
            2: rb = '0;
            default: ;
          endcase
          r_iv    = ($urandom_range(0, 3) != 0);
          r_a     = ra[W-1:0];
          r_b     = rb[W-1:0];
          r_cin   = 1'($urandom_range(0, 1));
          r_sub   = 1'($urandom_range(0, 1));
          r_chain = ($urandom_range(0, 2) == 0);
        end else begin
          r_iv = 1'b0;
        end
        r_or = (cyc >= 2900) || ($urandom_range(0, 3) != 0);
        #1;
        if (r_ov) begin
          if (q.size() == 0) begin
            check($sformatf("rand%0d spurious", W), 1, 0);
          end else begin
            e = q[0];
            check($sformatf("rand%0d sum", W), r_sum, e[W-1:0]);
            check($sformatf("rand%0d cout", W), r_cout, e[W]);
            check($sformatf("rand%0d ovf", W), r_ovf, e[W+1]);
            if (r_or) void'(q.pop_front());
          end
        end
        if (r_iv && r_ir) begin
          be   = r_sub ? ~r_b : r_b;
          ce   = r_chain ? mc : (r_sub ? 1'b1 : r_cin);
          full = {1'b0, r_a} + {1'b0, be} + {{W{1'b0}}, ce};
          o    = (r_a[W-1] == be[W-1]) && (full[W-1] != r_a[W-1]);
          q.push_back({o, full});
          mc = full[W];
        end
      end
      check($sformatf("rand%0d drain", W), q.size(), 0);
      rand_done++;
    end
  end
endmodule
`default_nettype wire
